// File: rtl/aoi_sweep_checker_if.sv
// aoi_sweep_checker_if
//   Groups the control and status signals of aoi_sweep_checker into one bundle.
//   The master side (bench or bring-up controller) drives start_i and inject_i.
//   The slave side (the checker) drives every status output.
//   Parameters must match those of the aoi_sweep_checker instance it is bound to.
//
//   start_i      master->slave  1      start a sweep (only sampled in IDLE)
//   inject_i     master->slave  WIDTH  fault mask XORed onto behavioural outputs
//   busy_o       slave->master  1      sweep or drain in progress
//   done_o       slave->master  1      one-cycle completion pulse
//   pass_o       slave->master  1      last sweep had zero mismatches
//   err_cnt_o    slave->master  ERR_W  mismatching vectors (saturating)
//   vec_idx_o    slave->master  IW     next vector index to issue
//   first_err_o  slave->master  IW     first mismatching vector index
interface aoi_sweep_checker_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_VEC = 16,
  parameter int ERR_W   = 8
);
  localparam int IW = $clog2(NUM_VEC);

  logic             start_i;
  logic [WIDTH-1:0] inject_i;
  logic             busy_o;
  logic             done_o;
  logic             pass_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [IW-1:0]    vec_idx_o;
  logic [IW-1:0]    first_err_o;

  modport master (
    output start_i, inject_i,
    input  busy_o, done_o, pass_o, err_cnt_o, vec_idx_o, first_err_o
  );

  modport slave (
    input  start_i, inject_i,
    output busy_o, done_o, pass_o, err_cnt_o, vec_idx_o, first_err_o
  );
endinterface

// File: rtl/aoi_sweep_checker.sv
// aoi_sweep_checker
//   WIDTH-lane and-or-invert unit (TZ = ~((A&B)|(C&D)) per lane) built twice,
//   once from gate primitives and once behaviourally. An FSM sweeps NUM_VEC
//   vectors through both copies in a two-stage pipeline, compares the results
//   and counts mismatching vectors in a saturating counter. Used as an
//   on-board self-test for bring-up.
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset (sync release expected)
//     bus    aoi_sweep_checker_if.slave: start_i, inject_i in;
//            busy_o, done_o, pass_o, err_cnt_o, vec_idx_o, first_err_o out
//
//   Build option: define AOI_FIRST_ERR_CAPTURE_EN to record the index of the
//   first mismatching vector of each sweep on first_err_o. Without it
//   first_err_o is tied to all ones and no capture logic exists.
module aoi_sweep_checker #(
  parameter int WIDTH   = 4,
  parameter int NUM_VEC = 16,
  parameter int ERR_W   = 8
) (
  input logic               clk,
  input logic               rst_n,
  aoi_sweep_checker_if.slave bus
);
  localparam int                IW       = $clog2(NUM_VEC);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic             drain_q, drain_d;
  logic [IW-1:0]    vec_idx_q, vec_idx_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic             sweep_start;

  // Stage 1: lane operands, fault mask and valid for the issued vector
  logic [WIDTH-1:0] s1_a_q, s1_b_q, s1_c_q, s1_d_q;
  logic [WIDTH-1:0] s1_a_d, s1_b_d, s1_c_d, s1_d_d;
  logic [WIDTH-1:0] s1_inj_q, s1_inj_d;
  logic             s1_valid_q, s1_valid_d;

  // Stage 2: both copies' results
  logic [WIDTH-1:0] s2_tz_gate_q, s2_tz_gate_d;
  logic [WIDTH-1:0] s2_tz_beh_q, s2_tz_beh_d;
  logic             s2_valid_q, s2_valid_d;

  logic [WIDTH-1:0] lane_pat;
  wire  [WIDTH-1:0] tz_gate;
  logic             mismatch;

  // Lane i sees (vec_idx + i) mod 16 as {A,B,C,D}, so lanes cover distinct
  // input combinations in every vector.
  always_comb begin
    s1_a_d     = '0;
    s1_b_d     = '0;
    s1_c_d     = '0;
    s1_d_d     = '0;
    lane_pat   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      lane_pat  = 4'(vec_idx_q) + 4'(i);
      s1_a_d[i] = lane_pat[3];
      s1_b_d[i] = lane_pat[2];
      s1_c_d[i] = lane_pat[1];
      s1_d_d[i] = lane_pat[0];
    end
    s1_inj_d   = bus.inject_i;
    s1_valid_d = (state_q == SWEEP);
  end

  // Gate-level copy, built from primitives so it is structurally independent
  // of the behavioural expression below.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    wire ab_w, cd_w;
    and u_and_ab (ab_w, s1_a_q[g], s1_b_q[g]);
    and u_and_cd (cd_w, s1_c_q[g], s1_d_q[g]);
    nor u_nor    (tz_gate[g], ab_w, cd_w);
  end

  always_comb begin
    s2_tz_gate_d = tz_gate;
    s2_tz_beh_d  = ~((s1_a_q & s1_b_q) | (s1_c_q & s1_d_q)) ^ s1_inj_q;
    s2_valid_d   = s1_valid_q;
  end

  // One mismatch per vector regardless of how many lanes differ
  assign mismatch = s2_valid_q && (s2_tz_gate_q != s2_tz_beh_q);

  // Sweep sequencing: IDLE -> SWEEP (NUM_VEC issues) -> DRAIN (2) -> DONE (1)
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    vec_idx_d   = vec_idx_q;
    pass_d      = pass_q;
    sweep_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d     = SWEEP;
          vec_idx_d   = '0;
          pass_d      = 1'b0;
          sweep_start = 1'b1;
        end
      end
      SWEEP: begin
        if (vec_idx_q == LAST_IDX) begin
          vec_idx_d = '0;
          drain_d   = 1'b0;
          state_d   = DRAIN;
        end else begin
          vec_idx_d = vec_idx_q + IW'(1);
        end
      end
      DRAIN: begin
        if (drain_q) begin
          drain_d = 1'b0;
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        // Counter already holds the final vector's contribution here
        pass_d  = (err_cnt_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sweep_start) begin
      err_cnt_d = '0;
    end else if (mismatch && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      drain_q      <= 1'b0;
      vec_idx_q    <= '0;
      err_cnt_q    <= '0;
      pass_q       <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_c_q       <= '0;
      s1_d_q       <= '0;
      s1_inj_q     <= '0;
      s1_valid_q   <= 1'b0;
      s2_tz_gate_q <= '0;
      s2_tz_beh_q  <= '0;
      s2_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      vec_idx_q    <= vec_idx_d;
      err_cnt_q    <= err_cnt_d;
      pass_q       <= pass_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_c_q       <= s1_c_d;
      s1_d_q       <= s1_d_d;
      s1_inj_q     <= s1_inj_d;
      s1_valid_q   <= s1_valid_d;
      s2_tz_gate_q <= s2_tz_gate_d;
      s2_tz_beh_q  <= s2_tz_beh_d;
      s2_valid_q   <= s2_valid_d;
    end
  end

`ifdef AOI_FIRST_ERR_CAPTURE_EN
  // Index travels alongside the vector so the capture names the right one
  logic [IW-1:0] s1_idx_q, s1_idx_d;
  logic [IW-1:0] s2_idx_q, s2_idx_d;
  logic [IW-1:0] first_err_q, first_err_d;
  logic          first_seen_q, first_seen_d;

  // A separate seen flag is needed because all ones is also a legal index
  always_comb begin
    s1_idx_d     = vec_idx_q;
    s2_idx_d     = s1_idx_q;
    first_err_d  = first_err_q;
    first_seen_d = first_seen_q;
    if (sweep_start) begin
      first_err_d  = '1;
      first_seen_d = 1'b0;
    end else if (mismatch && !first_seen_q) begin
      first_err_d  = s2_idx_q;
      first_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_idx_q     <= '0;
      s2_idx_q     <= '0;
      first_err_q  <= '1;
      first_seen_q <= 1'b0;
    end else begin
      s1_idx_q     <= s1_idx_d;
      s2_idx_q     <= s2_idx_d;
      first_err_q  <= first_err_d;
      first_seen_q <= first_seen_d;
    end
  end

  assign bus.first_err_o = first_err_q;
`else
  assign bus.first_err_o = '1;
`endif

  assign bus.busy_o    = (state_q == SWEEP) || (state_q == DRAIN);
  assign bus.done_o    = (state_q == DONE);
  assign bus.pass_o    = pass_q;
  assign bus.err_cnt_o = err_cnt_q;
  assign bus.vec_idx_o = vec_idx_q;
endmodule

// File: tb/tb_aoi_sweep_checker.sv
// tb_aoi_sweep_checker
//   Directed bench for aoi_sweep_checker. Two instances share stimulus: one with
//   ERR_W=8 and one with ERR_W=3 to exercise counter saturation. Whole-sweep
//   cases come from a record table; reset mid-sweep, start while busy and
//   start held high are hand-written sequences.
module tb_aoi_sweep_checker;
  localparam int WIDTH   = 4;
  localparam int NUM_VEC = 16;
  localparam int ERR_W   = 8;
  localparam int SAT_W   = 3;
  localparam int ALL1    = 15;
  localparam int LATENCY = NUM_VEC + 2;

`ifdef AOI_FIRST_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aoi_sweep_checker_if #(.WIDTH(WIDTH), .NUM_VEC(NUM_VEC), .ERR_W(ERR_W)) bus ();
  aoi_sweep_checker_if #(.WIDTH(WIDTH), .NUM_VEC(NUM_VEC), .ERR_W(SAT_W)) sat_bus ();

  assign sat_bus.start_i  = bus.start_i;
  assign sat_bus.inject_i = bus.inject_i;

  aoi_sweep_checker #(.WIDTH(WIDTH), .NUM_VEC(NUM_VEC), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  aoi_sweep_checker #(.WIDTH(WIDTH), .NUM_VEC(NUM_VEC), .ERR_W(SAT_W)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sat_bus)
  );

  typedef struct {
    string      name;
    logic [3:0] inj;
    int         inj_vec;
    int         exp_err;
    int         exp_pass;
    int         exp_first;
    int         exp_sat_err;
  } sweep_rec_t;

  sweep_rec_t tbl[6];

  // Compare one value and account for it in the running totals
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one sweep and follow it to the done pulse. inj_vec < 0 holds inj
  // for the whole sweep; otherwise inj is applied only on the edge issuing
  // vector inj_vec. Returns edges from start sample to done and busy cycles.
  task automatic applyStimulus(input logic [3:0] inj, input int inj_vec,
                               output int done_edges, output int busy_cycles);
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.inject_i = (inj_vec < 0) ? inj : 4'b0000;
    @(posedge clk);
    done_edges  = 0;
    busy_cycles = 0;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (!bus.done_o && done_edges < 100) begin
      if (bus.busy_o) busy_cycles++;
      if (inj_vec >= 0)
        bus.inject_i = (bus.busy_o && int'(bus.vec_idx_o) == inj_vec) ? inj : 4'b0000;
      @(posedge clk);
      done_edges++;
      @(negedge clk);
    end
    bus.inject_i = 4'b0000;
  endtask

  // Full result check after a sweep: timing, then settled status after DONE
  task automatic checkSweep(input string name, input int done_edges, input int busy_cycles,
                            input int exp_err, input int exp_pass, input int exp_first,
                            input int exp_sat_err);
    checkOutput({name, ".done_latency"}, done_edges, LATENCY);
    checkOutput({name, ".busy_cycles"}, busy_cycles, LATENCY);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, ".done_low"}, int'(bus.done_o), 0);
    checkOutput({name, ".busy_low"}, int'(bus.busy_o), 0);
    checkOutput({name, ".err_cnt"}, int'(bus.err_cnt_o), exp_err);
    checkOutput({name, ".pass"}, int'(bus.pass_o), exp_pass);
    checkOutput({name, ".first_err"}, int'(bus.first_err_o), exp_first);
    checkOutput({name, ".vec_idx"}, int'(bus.vec_idx_o), 0);
    checkOutput({name, ".sat_err_cnt"}, int'(sat_bus.err_cnt_o), exp_sat_err);
    checkOutput({name, ".sat_pass"}, int'(sat_bus.pass_o), (exp_sat_err == 0) ? 1 : 0);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, ".busy"}, int'(bus.busy_o), 0);
    checkOutput({name, ".done"}, int'(bus.done_o), 0);
    checkOutput({name, ".pass"}, int'(bus.pass_o), 0);
    checkOutput({name, ".err_cnt"}, int'(bus.err_cnt_o), 0);
    checkOutput({name, ".vec_idx"}, int'(bus.vec_idx_o), 0);
    checkOutput({name, ".first_err"}, int'(bus.first_err_o), ALL1);
    checkOutput({name, ".sat_err_cnt"}, int'(sat_bus.err_cnt_o), 0);
  endtask

  initial begin
    int edges;
    int busy;
    int dones;
    int waited;
    bit pulsed;

    // Expected values worked out by hand: one count per faulted vector,
    // first_err names the first faulted vector, ERR_W=3 saturates at 7.
    tbl[0] = '{"clean",       4'b0000, -1,  0, 1, ALL1,             0};
    tbl[1] = '{"const_fault", 4'b0001, -1, 16, 0, CAP ? 0  : ALL1,  7};
    tbl[2] = '{"single_v5",   4'b1000,  5,  1, 0, CAP ? 5  : ALL1,  1};
    tbl[3] = '{"all_lanes",   4'b1111, -1, 16, 0, CAP ? 0  : ALL1,  7};
    tbl[4] = '{"single_v0",   4'b0110,  0,  1, 0, CAP ? 0  : ALL1,  1};
    tbl[5] = '{"single_v15",  4'b0100, 15,  1, 0, ALL1,             1};

    bus.start_i  = 1'b0;
    bus.inject_i = 4'b0000;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      $display("[TB] sweep %s", tbl[i].name);
      applyStimulus(tbl[i].inj, tbl[i].inj_vec, edges, busy);
      checkSweep(tbl[i].name, edges, busy, tbl[i].exp_err, tbl[i].exp_pass,
                 tbl[i].exp_first, tbl[i].exp_sat_err);
    end

    // Reset while vector 9 is next: everything returns to reset values and
    // the in-flight vectors never reach the counter.
    $display("[TB] reset mid-sweep");
    @(negedge clk);
    bus.start_i  = 1'b1;
    bus.inject_i = 4'b1111;
    @(negedge clk);
    bus.start_i = 1'b0;
    waited = 0;
    while (int'(bus.vec_idx_o) != 9 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midrst.reach_idx9", int'(bus.vec_idx_o), 9);
    rst_n = 1'b0;
    #1;
    checkResetValues("midrst");
    @(negedge clk);
    bus.inject_i = 4'b0000;
    rst_n        = 1'b1;
    @(negedge clk);
    applyStimulus(4'b0000, -1, edges, busy);
    checkSweep("after_rst", edges, busy, 0, 1, ALL1, 0);

    // Extra start while busy must not restart or add a second done pulse
    $display("[TB] start while busy");
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_i = 1'b0;
    dones  = 0;
    pulsed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!pulsed && bus.busy_o && int'(bus.vec_idx_o) == 3) begin
        bus.start_i = 1'b1;
        pulsed      = 1'b1;
      end else begin
        bus.start_i = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.done_o) dones++;
    end
    bus.start_i = 1'b0;
    checkOutput("busy_start.pulsed", int'(pulsed), 1);
    checkOutput("busy_start.done_pulses", dones, 1);
    checkOutput("busy_start.err_cnt", int'(bus.err_cnt_o), 0);
    checkOutput("busy_start.pass", int'(bus.pass_o), 1);
    checkOutput("busy_start.idle", int'(bus.busy_o), 0);

    // Start held high: next sweep begins from the IDLE cycle after DONE
    $display("[TB] start held high");
    @(negedge clk);
    bus.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    edges = 0;
    while (!bus.done_o && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("held.done_latency", edges, LATENCY);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held.idle_busy", int'(bus.busy_o), 0);
    checkOutput("held.idle_pass", int'(bus.pass_o), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held.restart_busy", int'(bus.busy_o), 1);
    checkOutput("held.restart_pass_clr", int'(bus.pass_o), 0);
    checkOutput("held.restart_idx", int'(bus.vec_idx_o), 0);
    bus.start_i = 1'b0;
    edges = 0;
    while (!bus.done_o && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput("held.second_done", int'(bus.done_o), 1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("held.second_pass", int'(bus.pass_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
